cpu_run_ctrl: RTL
=================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The module SHALL have parameter STEP_W, default 16, giving the step-count width.
REQ-002 The module SHALL have parameter CYC_W, default 32, giving the executed-cycle counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 init_calib_complete  input  1  memory calibration done, level.
REQ-006 cmd_start  input  1  free-run request, 1-cycle pulse from command decoder.
REQ-007 cmd_step  input  1  run-N-cycles request, 1-cycle pulse.
REQ-008 cmd_quit  input  1  stop request, 1-cycle pulse.
REQ-009 step_count  input  STEP_W  number of unstalled cycles for cmd_step; sampled with cmd_step.
REQ-010 stall  input  1  CPU stall from the status block; high = no progress this cycle.
REQ-011 cpu_start  output  1  start pulse to the status block.
REQ-012 quit_cmd  output  1  quit pulse to the status block.
REQ-013 running  output  1  high in RUN or STEP state.
REQ-014 step_done  output  1  1-cycle pulse when a step sequence completes normally.
REQ-015 calib_lost  output  1  sticky flag: calibration dropped while running.
REQ-016 run_cycles  output  CYC_W  count of unstalled cycles since the last start.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_CAL, RUN and STEP; encoding is free.
REQ-018 Simultaneous commands SHALL be prioritised cmd_quit > cmd_step > cmd_start; lower-priority commands in the same cycle are dropped.
REQ-019 In IDLE, cmd_start with init_calib_complete=1 SHALL assert cpu_start for exactly one cycle, the cycle after sampling, and enter RUN.
REQ-020 In IDLE, cmd_start with init_calib_complete=0 SHALL enter WAIT_CAL with mode=RUN and no pulse.
REQ-021 In IDLE, cmd_step with step_count!=0 SHALL load the remaining counter with step_count and behave as REQ-019/020 with mode=STEP; step_count=0 SHALL be ignored (stay IDLE, no outputs).
REQ-022 In WAIT_CAL, the first cycle with init_calib_complete=1 SHALL issue a one-cycle cpu_start the next cycle and enter the stored mode (RUN or STEP).
REQ-023 In WAIT_CAL, cmd_quit SHALL return to IDLE with no cpu_start and no quit_cmd.
REQ-024 In RUN or STEP, cmd_start and cmd_step SHALL be ignored.
REQ-025 In RUN or STEP, cmd_quit SHALL assert quit_cmd for exactly one cycle, the cycle after sampling, and enter IDLE; step_done SHALL NOT pulse.
REQ-026 In STEP, the remaining counter SHALL decrement by 1 on each cycle with stall=0.
REQ-027 When remaining=1 and stall=0 in STEP, the next cycle SHALL assert quit_cmd and step_done together for one cycle and enter IDLE.
REQ-028 If init_calib_complete falls in RUN or STEP, the next state SHALL be IDLE, with calib_lost set and no quit_cmd.
REQ-029 A cmd_start or cmd_step accepted from IDLE SHALL clear calib_lost.
REQ-030 run_cycles SHALL clear to 0 on the cycle cpu_start is asserted.
REQ-031 run_cycles SHALL increment on each RUN/STEP cycle with stall=0.
REQ-032 run_cycles SHALL saturate at all-ones and hold its value in IDLE/WAIT_CAL.
REQ-033 cpu_start and quit_cmd SHALL be registered and never high in the same cycle.
REQ-034 running SHALL be registered and high exactly while state is RUN or STEP.

Reset
REQ-035 With rst_n=0 at a clock edge, state SHALL become IDLE, and cpu_start, quit_cmd, running, step_done, calib_lost, run_cycles and the remaining counter SHALL all become 0.
REQ-036 Reset asserted mid-RUN or mid-STEP SHALL abort silently, with no quit_cmd pulse.
REQ-037 All commands SHALL be ignored while rst_n=0.

Verification
REQ-038 Calib=1, cmd_start at T -> cpu_start=1 only at T+1; running=1 from T+1; cmd_quit at T+10 -> quit_cmd=1 only at T+11, running=0 at T+11.
REQ-039 Calib=0, cmd_step with step_count=3, calib rises at T+5 -> cpu_start at T+6; with stall low from T+7, quit_cmd and step_done both high at T+10 only; run_cycles=3.
REQ-040 STEP with step_count=4 and stall high on 2 of the intervening cycles -> completion delayed by exactly 2 cycles; run_cycles=4.
REQ-041 cmd_start, cmd_step and cmd_quit in the same cycle in IDLE -> no outputs; cmd_step(5) with cmd_start in IDLE -> STEP mode, remaining=5.
REQ-042 Calib drops in RUN -> IDLE next cycle, calib_lost=1, no quit_cmd; next cmd_start clears calib_lost.
REQ-043 rst_n=0 for one cycle mid-STEP -> all outputs 0 at the next edge, no quit_cmd; cmd_step with step_count=0 -> no response.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Command/status bundle between the host command decoder, the CPU status
// block and the run controller. The controller sits on the slave side.
interface cpu_run_ctrl_if #(
    parameter int STEP_W = 16,
    parameter int CYC_W  = 32
);
    logic              init_calib_complete;
    logic              cmd_start;
    logic              cmd_step;
    logic              cmd_quit;
    logic [STEP_W-1:0] step_count;
    logic              stall;

    logic              cpu_start;
    logic              quit_cmd;
    logic              running;
    logic              step_done;
    logic              calib_lost;
    logic [CYC_W-1:0]  run_cycles;

    modport master (
        output init_calib_complete, cmd_start, cmd_step, cmd_quit, step_count, stall,
        input  cpu_start, quit_cmd, running, step_done, calib_lost, run_cycles
    );

    modport slave (
        input  init_calib_complete, cmd_start, cmd_step, cmd_quit, step_count, stall,
        output cpu_start, quit_cmd, running, step_done, calib_lost, run_cycles
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: turns start / step / quit commands into cpu_start and
// quit_cmd pulses, waits for memory calibration before launching, counts
// unstalled cycles and stops a step sequence after the requested count.
module cpu_run_ctrl #(
    parameter int STEP_W = 16,
    parameter int CYC_W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_CAL,
        S_RUN,
        S_STEP
    } state_t;

    localparam logic [CYC_W-1:0]  CYC_MAX  = '1;
    localparam logic [CYC_W-1:0]  CYC_ONE  = CYC_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    state_t            state_q, state_d;
    logic              mode_step_q, mode_step_d;   // launch mode remembered across WAIT_CAL
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic              cpu_start_q, cpu_start_d;
    logic              quit_cmd_q, quit_cmd_d;
    logic              running_q, running_d;
    logic              step_done_q, step_done_d;
    logic              calib_lost_q, calib_lost_d;
    logic [CYC_W-1:0]  run_cycles_q, run_cycles_d;

    logic              active;
    logic              accept;

    // Next-state and registered-output logic; defaults hold state and clear pulses.
    always_comb begin
        state_d      = state_q;
        mode_step_d  = mode_step_q;
        remaining_d  = remaining_q;
        cpu_start_d  = 1'b0;
        quit_cmd_d   = 1'b0;
        step_done_d  = 1'b0;
        calib_lost_d = calib_lost_q;
        run_cycles_d = run_cycles_q;
        accept       = 1'b0;

        active = (state_q == S_RUN) || (state_q == S_STEP);

        // Progress bookkeeping happens on every unstalled active cycle,
        // whatever command or calibration event ends the run this cycle.
        if (active && !bus.stall && (run_cycles_q != CYC_MAX)) begin
            run_cycles_d = run_cycles_q + CYC_ONE;
        end
        if ((state_q == S_STEP) && !bus.stall && (remaining_q != '0)) begin
            remaining_d = remaining_q - STEP_ONE;
        end

        case (state_q)
            S_IDLE: begin
                // Quit outranks everything; a zero-length step still wins
                // arbitration, so a start in the same cycle is dropped.
                if (bus.cmd_quit) begin
                    accept = 1'b0;
                end else if (bus.cmd_step) begin
                    if (bus.step_count != '0) begin
                        accept      = 1'b1;
                        mode_step_d = 1'b1;
                        remaining_d = bus.step_count;
                    end
                end else if (bus.cmd_start) begin
                    accept      = 1'b1;
                    mode_step_d = 1'b0;
                end

                if (accept) begin
                    calib_lost_d = 1'b0;
                    if (bus.init_calib_complete) begin
                        cpu_start_d = 1'b1;
                        state_d     = mode_step_d ? S_STEP : S_RUN;
                    end else begin
                        state_d = S_WAIT_CAL;
                    end
                end
            end

            S_WAIT_CAL: begin
                if (bus.cmd_quit) begin
                    state_d = S_IDLE;
                end else if (bus.init_calib_complete) begin
                    cpu_start_d = 1'b1;
                    state_d     = mode_step_q ? S_STEP : S_RUN;
                end
            end

            S_RUN, S_STEP: begin
                // Losing calibration aborts without telling the status block.
                if (!bus.init_calib_complete) begin
                    state_d      = S_IDLE;
                    calib_lost_d = 1'b1;
                end else if (bus.cmd_quit) begin
                    state_d    = S_IDLE;
                    quit_cmd_d = 1'b1;
                end else if ((state_q == S_STEP) && !bus.stall && (remaining_q == STEP_ONE)) begin
                    state_d     = S_IDLE;
                    quit_cmd_d  = 1'b1;
                    step_done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cpu_start_d) begin
            run_cycles_d = '0;
        end

        running_d = (state_d == S_RUN) || (state_d == S_STEP);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_step_q  <= 1'b0;
            remaining_q  <= '0;
            cpu_start_q  <= 1'b0;
            quit_cmd_q   <= 1'b0;
            running_q    <= 1'b0;
            step_done_q  <= 1'b0;
            calib_lost_q <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_step_q  <= mode_step_d;
            remaining_q  <= remaining_d;
            cpu_start_q  <= cpu_start_d;
            quit_cmd_q   <= quit_cmd_d;
            running_q    <= running_d;
            step_done_q  <= step_done_d;
            calib_lost_q <= calib_lost_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign bus.cpu_start  = cpu_start_q;
    assign bus.quit_cmd   = quit_cmd_q;
    assign bus.running    = running_q;
    assign bus.step_done  = step_done_q;
    assign bus.calib_lost = calib_lost_q;
    assign bus.run_cycles = run_cycles_q;

endmodule
